// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter/sequencer between instruction fetch (A)
// and data load/store (B) in front of a single-port synchronous memory.
// Each transaction takes IDLE(grant) -> ACCESS -> RESP, and the ack pulse
// lands in the following IDLE cycle.
module mem_arbiter #(
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 64,
  localparam int AW       = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_wr,
  input  logic [AW-1:0]     a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_wr,
  input  logic [AW-1:0]     b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic [AW-1:0]     mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state;
  // Remembers whether the in-flight transaction is a write, since mem_we is
  // already back to read mode by the time the response is produced.
  logic   op_wr;
  logic   pick_b;

  // B wins when it is the only requester, or on a tie when A went last.
  always_comb begin
    pick_b = b_req & (~a_req | ~owner);
  end

  // Arbitration, memory sequencing and response generation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op_wr     <= 1'b0;
      mem_we    <= 1'b1;
      mem_addr  <= '0;
      mem_wdata <= '0;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      a_rdata   <= '0;
      b_rdata   <= '0;
      busy      <= 1'b0;
      owner     <= 1'b1;
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      case (state)
        IDLE: begin
          mem_we <= 1'b1;
          if (a_req || b_req) begin
            state <= ACCESS;
            busy  <= 1'b1;
            owner <= pick_b;
            if (pick_b) begin
              mem_addr  <= b_addr;
              mem_wdata <= b_wdata;
              mem_we    <= ~b_wr;
              op_wr     <= b_wr;
            end else begin
              mem_addr  <= a_addr;
              mem_wdata <= a_wdata;
              mem_we    <= ~a_wr;
              op_wr     <= a_wr;
            end
          end
        end
        ACCESS: begin
          // The memory acts at this edge; return it to read mode at once.
          mem_we <= 1'b1;
          state  <= RESP;
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
          if (owner) begin
            b_ack <= 1'b1;
            if (!op_wr) b_rdata <= mem_rdata;
          end else begin
            a_ack <= 1'b1;
            if (!op_wr) a_rdata <= mem_rdata;
          end
        end
        default: begin
          state  <= IDLE;
          mem_we <= 1'b1;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed, table-driven bench for mem_arbiter with a simple
// synchronous memory attached to the memory pins.
module tb_mem_arbiter;

  localparam int DATA_W    = 8;
  localparam int MEM_DEPTH = 64;
  localparam int AW        = $clog2(MEM_DEPTH);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              a_req = 1'b0, a_wr = 1'b0, b_req = 1'b0, b_wr = 1'b0;
  logic [AW-1:0]     a_addr = '0, b_addr = '0;
  logic [DATA_W-1:0] a_wdata = '0, b_wdata = '0;
  logic              a_ack, b_ack, mem_we, busy, owner;
  logic [DATA_W-1:0] a_rdata, b_rdata, mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [AW-1:0]     mem_addr;

  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic [DATA_W-1:0] snap [MEM_DEPTH];
  logic              mem_init = 1'b1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  // Single-port synchronous memory: mem_we low writes, high reads.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= 8'(8'h40 + i);
      mem_rdata <= '0;
    end else if (!mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end else begin
      mem_rdata <= mem[mem_addr];
    end
  end

  typedef struct {
    logic              rst;
    logic              a_req, a_wr;
    logic [AW-1:0]     a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              b_req, b_wr;
    logic [AW-1:0]     b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              x_a_ack, x_b_ack, x_mem_we, x_busy, x_owner;
    logic [DATA_W-1:0] x_a_rdata, x_b_rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int r, input int ar, input int aw, input int aa,
                              input int ad, input int br, input int bw, input int ba,
                              input int bd, input int xaa, input int xba, input int xwe,
                              input int xbu, input int xow, input int xar, input int xbr);
    vec_t v;
    v.rst = 1'(r);    v.a_req = 1'(ar); v.a_wr = 1'(aw);
    v.a_addr = AW'(aa); v.a_wdata = DATA_W'(ad);
    v.b_req = 1'(br); v.b_wr = 1'(bw);
    v.b_addr = AW'(ba); v.b_wdata = DATA_W'(bd);
    v.x_a_ack = 1'(xaa); v.x_b_ack = 1'(xba); v.x_mem_we = 1'(xwe);
    v.x_busy = 1'(xbu); v.x_owner = 1'(xow);
    v.x_a_rdata = DATA_W'(xar); v.x_b_rdata = DATA_W'(xbr);
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    rst = v.rst;
    a_req = v.a_req; a_wr = v.a_wr; a_addr = v.a_addr; a_wdata = v.a_wdata;
    b_req = v.b_req; b_wr = v.b_wr; b_addr = v.b_addr; b_wdata = v.b_wdata;
    @(posedge clk);
    #1;
    $display("step %0d: rst=%0b a_req=%0b b_req=%0b -> a_ack=%0b b_ack=%0b mem_we=%0b busy=%0b owner=%0b a_rdata=%02h b_rdata=%02h",
             idx, rst, a_req, b_req, a_ack, b_ack, mem_we, busy, owner, a_rdata, b_rdata);
    chk("a_ack",   idx, 32'(a_ack),   32'(v.x_a_ack));
    chk("b_ack",   idx, 32'(b_ack),   32'(v.x_b_ack));
    chk("mem_we",  idx, 32'(mem_we),  32'(v.x_mem_we));
    chk("busy",    idx, 32'(busy),    32'(v.x_busy));
    chk("owner",   idx, 32'(owner),   32'(v.x_owner));
    chk("a_rdata", idx, 32'(a_rdata), 32'(v.x_a_rdata));
    chk("b_rdata", idx, 32'(b_rdata), 32'(v.x_b_rdata));
  endtask

  initial begin
    // Reset values
    vecs.push_back(mk(1, 0,0,0,0,     0,0,0,0,        0,0,1,0,1, 'h00,'h00));
    // A write 5 <- 0x3C, then A read 5
    vecs.push_back(mk(0, 1,1,5,'h3C,  0,0,0,0,        0,0,0,1,0, 'h00,'h00));
    vecs.push_back(mk(0, 1,1,5,'h3C,  0,0,0,0,        0,0,1,1,0, 'h00,'h00));
    vecs.push_back(mk(0, 1,1,5,'h3C,  0,0,0,0,        1,0,1,0,0, 'h00,'h00));
    vecs.push_back(mk(0, 0,0,0,0,     0,0,0,0,        0,0,1,0,0, 'h00,'h00));
    vecs.push_back(mk(0, 1,0,5,0,     0,0,0,0,        0,0,1,1,0, 'h00,'h00));
    vecs.push_back(mk(0, 1,0,5,0,     0,0,0,0,        0,0,1,1,0, 'h00,'h00));
    vecs.push_back(mk(0, 1,0,5,0,     0,0,0,0,        1,0,1,0,0, 'h3C,'h00));
    vecs.push_back(mk(0, 0,0,0,0,     0,0,0,0,        0,0,1,0,0, 'h3C,'h00));
    // Reset, then A read 2 and B write 9 <- 0xA5 on the same edge
    vecs.push_back(mk(1, 0,0,0,0,     0,0,0,0,        0,0,1,0,1, 'h00,'h00));
    vecs.push_back(mk(0, 1,0,2,0,     1,1,9,'hA5,     0,0,1,1,0, 'h00,'h00));
    vecs.push_back(mk(0, 1,0,2,0,     1,1,9,'hA5,     0,0,1,1,0, 'h00,'h00));
    vecs.push_back(mk(0, 1,0,2,0,     1,1,9,'hA5,     1,0,1,0,0, 'h42,'h00));
    vecs.push_back(mk(0, 0,0,0,0,     1,1,9,'hA5,     0,0,0,1,1, 'h42,'h00));
    vecs.push_back(mk(0, 0,0,0,0,     1,1,9,'hA5,     0,0,1,1,1, 'h42,'h00));
    vecs.push_back(mk(0, 0,0,0,0,     1,1,9,'hA5,     0,1,1,0,1, 'h42,'h00));
    vecs.push_back(mk(0, 0,0,0,0,     0,0,0,0,        0,0,1,0,1, 'h42,'h00));
    // Both held: A reads 1..3, B writes 0x10..0x12 to 20..22, alternating
    vecs.push_back(mk(0, 1,0,1,0,     1,1,20,'h10,    0,0,1,1,0, 'h42,'h00));
    vecs.push_back(mk(0, 1,0,1,0,     1,1,20,'h10,    0,0,1,1,0, 'h42,'h00));
    vecs.push_back(mk(0, 1,0,1,0,     1,1,20,'h10,    1,0,1,0,0, 'h41,'h00));
    vecs.push_back(mk(0, 1,0,2,0,     1,1,20,'h10,    0,0,0,1,1, 'h41,'h00));
    vecs.push_back(mk(0, 1,0,2,0,     1,1,20,'h10,    0,0,1,1,1, 'h41,'h00));
    vecs.push_back(mk(0, 1,0,2,0,     1,1,20,'h10,    0,1,1,0,1, 'h41,'h00));
    vecs.push_back(mk(0, 1,0,2,0,     1,1,21,'h11,    0,0,1,1,0, 'h41,'h00));
    vecs.push_back(mk(0, 1,0,2,0,     1,1,21,'h11,    0,0,1,1,0, 'h41,'h00));
    vecs.push_back(mk(0, 1,0,2,0,     1,1,21,'h11,    1,0,1,0,0, 'h42,'h00));
    vecs.push_back(mk(0, 1,0,3,0,     1,1,21,'h11,    0,0,0,1,1, 'h42,'h00));
    vecs.push_back(mk(0, 1,0,3,0,     1,1,21,'h11,    0,0,1,1,1, 'h42,'h00));
    vecs.push_back(mk(0, 1,0,3,0,     1,1,21,'h11,    0,1,1,0,1, 'h42,'h00));
    vecs.push_back(mk(0, 1,0,3,0,     1,1,22,'h12,    0,0,1,1,0, 'h42,'h00));
    vecs.push_back(mk(0, 1,0,3,0,     1,1,22,'h12,    0,0,1,1,0, 'h42,'h00));
    vecs.push_back(mk(0, 1,0,3,0,     1,1,22,'h12,    1,0,1,0,0, 'h43,'h00));
    vecs.push_back(mk(0, 0,0,0,0,     1,1,22,'h12,    0,0,0,1,1, 'h43,'h00));
    vecs.push_back(mk(0, 0,0,0,0,     1,1,22,'h12,    0,0,1,1,1, 'h43,'h00));
    vecs.push_back(mk(0, 0,0,0,0,     1,1,22,'h12,    0,1,1,0,1, 'h43,'h00));
    vecs.push_back(mk(0, 0,0,0,0,     0,0,0,0,        0,0,1,0,1, 'h43,'h00));
    // B only, read addr 20 held for 4 transactions; owner stays 1
    for (int k = 0; k < 4; k++) begin
      vecs.push_back(mk(0, 0,0,0,0,   1,0,20,0,       0,0,1,1,1, 'h43,(k == 0) ? 'h00 : 'h10));
      vecs.push_back(mk(0, 0,0,0,0,   1,0,20,0,       0,0,1,1,1, 'h43,(k == 0) ? 'h00 : 'h10));
      vecs.push_back(mk(0, 0,0,0,0,   1,0,20,0,       0,1,1,0,1, 'h43,'h10));
    end
    vecs.push_back(mk(0, 0,0,0,0,     0,0,0,0,        0,0,1,0,1, 'h43,'h10));

    // Hold reset over the memory-initialisation edge
    @(posedge clk);
    #1 mem_init = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], i);
      if (i == 16) chk("mem9", i, 32'(mem[9]), 32'h0A5);
      if (i == 8)  chk("mem5", i, 32'(mem[5]), 32'h03C);
    end
    chk("mem20", 100, 32'(mem[20]), 32'h010);
    chk("mem21", 101, 32'(mem[21]), 32'h011);
    chk("mem22", 102, 32'(mem[22]), 32'h012);

    // Reset in the middle of a B write ACCESS cycle aborts the write
    @(negedge clk);
    b_req = 1'b1; b_wr = 1'b1; b_addr = 7; b_wdata = 8'hFF;
    @(posedge clk);
    #1;
    $display("abort: grant B write 7 mem_we=%0b busy=%0b", mem_we, busy);
    chk("abort_grant_we", 200, 32'(mem_we), 32'd0);
    chk("abort_mem_addr", 200, 32'(mem_addr), 32'd7);
    @(negedge clk);
    rst = 1'b1;
    b_req = 1'b0; b_wr = 1'b0; b_addr = '0; b_wdata = '0;
    #1;
    $display("abort: rst mid-ACCESS mem_we=%0b busy=%0b owner=%0b", mem_we, busy, owner);
    chk("abort_we",     201, 32'(mem_we),    32'd1);
    chk("abort_busy",   201, 32'(busy),      32'd0);
    chk("abort_owner",  201, 32'(owner),     32'd1);
    chk("abort_addr",   201, 32'(mem_addr),  32'd0);
    chk("abort_wdata",  201, 32'(mem_wdata), 32'd0);
    chk("abort_rdata",  201, 32'(a_rdata | b_rdata), 32'd0);
    @(posedge clk);
    #1;
    chk("abort_mem7", 202, 32'(mem[7]), 32'h047);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      chk("abort_no_ack", 203 + c, 32'(b_ack | a_ack), 32'd0);
    end

    // Idle with no requests: memory stays in read mode and untouched
    for (int i = 0; i < MEM_DEPTH; i++) snap[i] = mem[i];
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      chk("idle_we",   300 + c, 32'(mem_we), 32'd1);
      chk("idle_busy", 300 + c, 32'(busy),   32'd0);
      chk("idle_ack",  300 + c, 32'(a_ack | b_ack), 32'd0);
    end
    $display("idle: 20 cycles done");
    for (int i = 0; i < MEM_DEPTH; i++) chk("idle_mem", i, 32'(mem[i]), 32'(snap[i]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port synchronous data/instruction memory of the microprocessor.
- Port A is instruction fetch; port B is data load/store.
- Serialises requests with round-robin fairness, drives the memory's address/write-data/mode pins, and returns read data with a one-cycle ack pulse.
- Memory mode convention: mem_we low = write, mem_we high = read. The memory acts on every posedge.

Parameters:
DATA_W, 8, data bus width (matches memory data_length)
MEM_DEPTH, 64, memory words; address width AW = $clog2(MEM_DEPTH)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
a_req  in  1  port A request; held until a_ack
a_wr  in  1  port A op: 1 = write, 0 = read
a_addr  in  AW  port A address
a_wdata  in  DATA_W  port A write data
a_ack  out  1  port A one-cycle completion pulse
a_rdata  out  DATA_W  port A read data; valid while a_ack high, held afterwards
b_req, b_wr, b_addr, b_wdata, b_ack, b_rdata  same as port A, for port B
mem_addr  out  AW  memory address, registered
mem_wdata  out  DATA_W  memory write data, registered
mem_we  out  1  memory mode, registered; 0 = write, 1 = read
mem_rdata  in  DATA_W  memory read data bus
busy  out  1  high in ACCESS and RESP
owner  out  1  port of current or last transaction (0 = A, 1 = B)

Behaviour:
- Reset (async) values:
  - state IDLE; mem_we = 1; mem_addr = 0; mem_wdata = 0.
  - a_ack = b_ack = 0; a_rdata = b_rdata = 0; busy = 0.
  - owner = 1, so A wins the first tie.
- FSM: IDLE -> ACCESS -> RESP -> IDLE. No other states.
- IDLE:
  - No req: stay; mem_we held 1, so a read-only idle never writes memory.
  - Exactly one req: grant that port.
  - Both req: grant the port != owner (round-robin).
  - On the grant edge: latch the winner's addr into mem_addr and wdata into mem_wdata; set mem_we = ~wr; owner = winner; go ACCESS.
- ACCESS:
  - Memory performs the op at the edge ending this cycle (write stored, or mem_rdata updated).
  - At that edge: mem_we forced back to 1; go RESP.
- RESP:
  - At the edge ending this cycle: pulse the owner's ack high for exactly one cycle.
  - For a read: owner's rdata <= mem_rdata. For a write: rdata unchanged.
  - Go IDLE.
- Latency:
  - req sampled at edge E0 -> ack high during the cycle after E2.
  - Throughput: one transaction per 3 cycles.
- The ack cycle is an IDLE cycle.
  - A req still high at the edge ending the ack cycle is a NEW transaction. The requester drops req during the ack cycle if it is done.
  - The arbitration in that cycle uses the updated owner, so two continuously-requesting ports alternate A,B,A,B.
- Requester inputs are sampled only at the grant edge. Changes after the grant do not affect the in-flight transaction.
- The non-granted port's ack stays 0. Its req stays pending and is served next.
- mem_we = 0 for exactly one cycle per write (ACCESS only). Never 0 in IDLE or RESP.
- Reset mid-operation:
  - Any state returns to IDLE; mem_we goes to 1 asynchronously, so an ACCESS-cycle write is aborted if reset precedes the edge.
  - No ack is issued for the aborted transaction; requesters re-request.
- Address is never out of range for MEM_DEPTH a power of 2. No bounds check.

Test Plan:
- A write addr 5 data 0x3C, then A read addr 5 -> mem_we low for 1 cycle only; a_ack pulses at cycle 3 of each transaction; read a_rdata = 0x3C; b_ack stays 0.
- A read addr 2 and B write addr 9 data 0xA5 requested same edge after reset -> A granted first (owner reset = 1); B granted at the edge ending a_ack cycle; b_ack 3 cycles later; mem[9] = 0xA5.
- A and B hold req for 6 transactions (A reads 1..3, B writes 0x10..0x12 to 20..22) -> acks alternate A,B,A,B,A,B, each 3 cycles apart; A reads correct data.
- B only, req held 4 transactions -> b_ack every 3rd cycle; owner stays 1; busy low only in the ack/IDLE cycles.
- B write addr 7 data 0xFF; rst asserted mid-ACCESS before the clock edge -> mem_we = 1 immediately, mem[7] unchanged, no b_ack, all outputs at reset values.
- Idle 20 cycles with no req -> mem_we constantly 1, busy 0, no ack, memory contents unchanged.
